// File: rtl/sva_pkg.sv
// Shared types for the SVA checker and its verdict collector.
// Checker state codes, verdict/record kinds, collector FSM, record header.
package sva_pkg;

  typedef enum logic signed [31:0] {
    S0    = 0,
    SEND  = -1,
    SLAZY = -2,
    S1    = 1,
    S2    = 2
  } sva_fsm_t;

  typedef enum logic [1:0] {
    V_NONE    = 2'd0,
    V_PASS    = 2'd1,
    V_FAIL    = 2'd2,
    V_VACUOUS = 2'd3
  } verdict_t;

  typedef enum logic {
    K_FAIL = 1'b0,
    K_LAZY = 1'b1
  } rec_kind_t;

  typedef enum logic [1:0] {
    C_RUN,
    C_DRAIN,
    C_REPORT
  } col_state_t;

  // Width-independent part of a record; the CYC_W
  // wide start/cycle stamps are appended by the user.
  typedef struct packed {
    rec_kind_t   kind;
    logic [31:0] state;
  } sva_rec_t;

  function automatic verdict_t judge(
    input logic any_bad,
    input logic any_good
  );
    if (any_bad)
      return V_FAIL;
    else if (any_good)
      return V_PASS;
    else
      return V_VACUOUS;
  endfunction

endpackage

// File: rtl/sva_rec_fifo.sv
// First-word-fall-through record FIFO, DEPTH a power of two.
// Ports: gclk/grst, clr, push/din, pop/dout, full, empty.
module sva_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty && !clr;
  // A pop in the same cycle frees the slot for a push at full.
  assign do_push = push && !clr && (!full || do_pop);

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  // Head is zero whenever nothing is queued.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sva_verdict_collector.sv
// Counts SVA checker outcomes, queues fail/lazy records, issues a final verdict.
// Ports: gclk/grst, in_* flags+context, eot, clr, rec_* stream, cnt_*, done, verdict.
module sva_verdict_collector
  import sva_pkg::*;
#(
  parameter int CYC_W    = 16,
  parameter int DEPTH    = 8,
  parameter int LOG_LAZY = 1
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             in_valid,
  input  logic             in_succ,
  input  logic             in_fail,
  input  logic             in_lazy,
  input  logic [31:0]      in_state,
  input  logic [CYC_W-1:0] in_start,
  input  logic             eot,
  input  logic             clr,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             rec_kind,
  output logic [31:0]      rec_state,
  output logic [CYC_W-1:0] rec_start,
  output logic [CYC_W-1:0] rec_cycle,
  output logic [CYC_W-1:0] cnt_succ,
  output logic [CYC_W-1:0] cnt_fail,
  output logic [CYC_W-1:0] cnt_lazy,
  output logic [CYC_W-1:0] cnt_drop,
  output logic             done,
  output verdict_t         verdict
);

  localparam int REC_W = $bits(sva_rec_t) + 2 * CYC_W;

  col_state_t       state_q;
  col_state_t       state_d;
  logic [CYC_W-1:0] cycle;
  logic             run;
  logic             sample;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  sva_rec_t         hdr_in;
  sva_rec_t         hdr_out;
  logic [REC_W-1:0] fifo_din;
  logic [REC_W-1:0] fifo_dout;

  function automatic logic [CYC_W-1:0] sat_inc(
    input logic [CYC_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign run    = (state_q == C_RUN);
  assign sample = run && in_valid && !clr;
  assign push   = sample &&
                  (in_fail || (in_lazy && (LOG_LAZY != 0)));
  assign pop    = rec_valid && rec_ready;
  assign drop   = push && full && !pop;

  always_comb begin
    hdr_in       = '0;
    hdr_in.kind  = in_fail ? K_FAIL : K_LAZY;
    hdr_in.state = in_state;
  end

  assign fifo_din = {hdr_in, in_start, cycle};

  sva_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .gclk  (gclk),
    .grst  (grst),
    .clr   (clr),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign {hdr_out, rec_start, rec_cycle} = fifo_dout;
  assign rec_valid = !empty;
  assign rec_kind  = hdr_out.kind;
  assign rec_state = hdr_out.state;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      cycle    <= '0;
      cnt_succ <= '0;
      cnt_fail <= '0;
      cnt_lazy <= '0;
      cnt_drop <= '0;
    end else if (clr) begin
      cycle    <= '0;
      cnt_succ <= '0;
      cnt_fail <= '0;
      cnt_lazy <= '0;
      cnt_drop <= '0;
    end else begin
      cycle    <= cycle + 1'b1;
      cnt_succ <= sat_inc(cnt_succ, sample && in_succ);
      cnt_fail <= sat_inc(cnt_fail, sample && in_fail);
      cnt_lazy <= sat_inc(cnt_lazy, sample && in_lazy);
      cnt_drop <= sat_inc(cnt_drop, drop);
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst)
      state_q <= C_RUN;
    else if (clr)
      state_q <= C_RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_RUN:    if (eot) state_d = C_DRAIN;
      C_DRAIN:  if (empty) state_d = C_REPORT;
      C_REPORT: state_d = C_REPORT;
      default:  state_d = C_RUN;
    endcase
  end

  // Counters are frozen once in DRAIN, so the verdict
  // taken on the DRAIN->REPORT edge is final.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      done    <= 1'b0;
      verdict <= V_NONE;
    end else if (clr) begin
      done    <= 1'b0;
      verdict <= V_NONE;
    end else if (state_q == C_DRAIN && empty) begin
      done    <= 1'b1;
      verdict <= judge(
        (cnt_fail != '0) || (cnt_drop != '0),
        (cnt_succ != '0) || (cnt_lazy != '0));
    end
  end

endmodule
